liteeth_sram_pkt_ring_ctrl: RTL and testbench
=============================================

// Module: liteeth_sram_pkt_ring_ctrl
// PURPOSE
//  Packet ring-buffer controller for one liteeth_1rw1r_32w384d_8_sram macro in the LiteEth MAC datapath.
//  Sink stream words are written through the macro's RW port; whole committed packets are read back through its R port to a source stream.
//  A packet becomes visible to the reader only after its last word is written.
//  A packet that overflows the buffer is dropped, and its partial data is rewound.
// PARAMETERS
//  DW       32   data width; equals macro BITS
//  DEPTH    384  ring depth in words; equals macro WORD_DEPTH
//  AW       9    address width; equals macro ADDR_WIDTH
//  MAX_PKTS 8    entries in the committed-packet end-address FIFO; power of 2
// PORTS
//  sys_clk       in   1   single clock; also drives macro clk0 and clk1
//  sys_rst       in   1   synchronous active-high reset
//  sink_valid    in   1   input word valid
//  sink_ready    out  1   input word accepted when valid&ready
//  sink_data     in   DW  input word
//  sink_last     in   1   final word of packet
//  source_valid  out  1   output word valid
//  source_ready  in   1   downstream accepts
//  source_data   out  DW  output word
//  source_last   out  1   final word of packet
//  drop          out  1   1-cycle pulse: packet discarded
//  level         out  AW  words held, including uncommitted words (0..DEPTH)
//  pkt_count     out  4   committed packets not yet fully read (0..MAX_PKTS)
//  sram_ce_rw1   out  1   to macro ce_rw1; equals sram_we_rw1
//  sram_we_rw1   out  1   to macro we_in_rw1
//  sram_wmask    out  DW  to macro w_mask_rw1; constant all-ones
//  sram_addr_rw1 out  AW  to macro addr_rw1 (wr_ptr)
//  sram_wd_rw1   out  DW  to macro wd_in_rw1; equals sink_data
//  sram_ce_r1    out  1   to macro ce_r1
//  sram_addr_r1  out  AW  to macro addr_r1 (rd_ptr)
//  sram_rd_r1    in   DW  from macro rd_out_r1; valid 1 cycle after ce_r1
// BEHAVIOUR
//  Reset: all pointers and counters are 0, FSM=IDLE, and every output is 0 except sram_wmask (all-ones).
//   An in-flight read is discarded on reset.
//  Pointers: wr_ptr, commit_ptr, rd_ptr wrap from DEPTH-1 to 0 (not power-of-2 wrap).
//  Write FSM:
//   IDLE/WRITE: sink_ready = !full && !pktfifo_full.
//    On accept: write sink_data at wr_ptr (combinational ce/we), wr_ptr++ and level++.
//    A non-last accept enters WRITE.
//    A last accept pushes the end address onto the packet FIFO, sets commit_ptr=wr_ptr+1 and returns to IDLE.
//   full := (level==DEPTH).
//    In WRITE with full=1 and sink_valid=1, the FSM enters DROP; no write occurs.
//    Also entered when a packet reaches DEPTH words without last.
//   DROP: sink_ready=1 and words are discarded.
//    On accepted last: wr_ptr=commit_ptr, level -= uncommitted count, drop pulses, and the FSM returns to IDLE.
//   In IDLE, full or pktfifo_full only deasserts sink_ready (back-pressure, no drop).
//  Read side:
//   A read is issued (ce_r1=1, rd_ptr++) when rd_ptr!=commit_ptr and the 2-entry output skid FIFO has room counting the in-flight read.
//   Data is captured 1 cycle later, with last = (addr == head end address).
//   The end-address FIFO pops when that last word is captured.
//   Sustained throughput is 1 word/cycle with source_ready=1.
//   First-word latency from commit: 2 cycles to source_valid.
//   source_valid is held with stable data until source_ready.
//   level-- on each source handshake.
//   pkt_count-- on each last handshake.
//  Same-cycle events:
//   Write and read in the same cycle: level is unchanged.
//   Reads only touch committed addresses, so RW/R never conflict on the same address.
//   Commit and a drop rewind cannot coincide.
//   Commit and a read-side pop in the same cycle: pkt_count is unchanged.
//  Zero-length packets do not exist: the last word is always a data word.
// TESTING
//  1. Reset, send a 4-word packet 0x1..0x4 -> sram writes at addr 0..3, source shows 0x1..0x4, last on 0x4, level back to 0.
//  2. Start at wr_ptr=380, send an 8-word packet -> addresses 380..383,0..3, data intact, last correct.
//  3. source_ready=0, send 3 packets totalling 384 words -> level=384, sink_ready=0, no drop; after 1 read handshake sink_ready=1.
//  4. Hold 380 words committed, send a 10-word packet -> drop pulses once after last, level=380, next packet is read intact.
//  5. Send 8 one-word packets with source_ready=0 -> pkt_count=8, 9th packet back-pressured until one pop.
//  6. Assert sys_rst mid-packet with a read in flight -> all outputs 0 next cycle, no stale source_valid, clean packet afterwards.

Source files
------------

// File: rtl/liteeth_sram_pkt_ring_ctrl.sv
// liteeth_sram_pkt_ring_ctrl
//   Packet ring-buffer controller for one liteeth_1rw1r_32w384d_8_sram macro.
//   Sink words are written through the macro RW port; whole committed packets
//   are read back through the R port into a 2-entry skid FIFO feeding the
//   source stream. A packet is visible to the reader only once its last word
//   is written; a packet that cannot fit is dropped and its words rewound.
// Ports
//   sys_clk, sys_rst           clock, synchronous active-high reset
//   sink_valid/ready/data/last input packet stream
//   source_valid/ready/data/last output packet stream
//   drop                       1-cycle pulse when a packet is discarded
//   level                      words held, including uncommitted words
//   pkt_count                  committed packets not yet fully read
//   sram_*_rw1                 macro write port (ce, we, mask, addr, data)
//   sram_ce_r1/addr_r1/rd_r1   macro read port, data valid 1 cycle after ce
module liteeth_sram_pkt_ring_ctrl #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 384,
  parameter int unsigned AW       = 9,
  parameter int unsigned MAX_PKTS = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          sink_valid,
  output logic          sink_ready,
  input  logic [DW-1:0] sink_data,
  input  logic          sink_last,
  output logic          source_valid,
  input  logic          source_ready,
  output logic [DW-1:0] source_data,
  output logic          source_last,
  output logic          drop,
  output logic [AW-1:0] level,
  output logic [3:0]    pkt_count,
  output logic          sram_ce_rw1,
  output logic          sram_we_rw1,
  output logic [DW-1:0] sram_wmask,
  output logic [AW-1:0] sram_addr_rw1,
  output logic [DW-1:0] sram_wd_rw1,
  output logic          sram_ce_r1,
  output logic [AW-1:0] sram_addr_r1,
  input  logic [DW-1:0] sram_rd_r1
);

  localparam int unsigned PW = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [AW-1:0] wr_count;   // words of the packet currently being written
  logic [AW-1:0] avail;      // committed words not yet issued to the R port
  logic          full, pkt_full;
  logic          wr_en, commit, rewind;

  logic [AW-1:0] pkt_end [MAX_PKTS];
  logic [PW-1:0] pf_wr, pf_rd;

  logic          inflight;
  logic [AW-1:0] rd_addr_q;
  logic          rd_issue, cap_last, src_hs;
  logic [2:0]    occ;
  logic [DW-1:0] skid_data [2];
  logic          skid_last [2];
  logic          skid_wp, skid_rp;
  logic [1:0]    skid_cnt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (level == AW'(DEPTH));
  assign pkt_full = (pkt_count == 4'(MAX_PKTS));

  // Write FSM: next state and write-side strobes.
  always_comb begin
    state_next = state;
    sink_ready = 1'b0;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;
    if (!sys_rst) begin
      case (state)
        IDLE, WRITE: begin
          if (state == WRITE && full && sink_valid) begin
            state_next = DROP;
          end else begin
            sink_ready = !full && !pkt_full;
            if (sink_valid && sink_ready) begin
              wr_en = 1'b1;
              if (sink_last) begin
                commit     = 1'b1;
                state_next = IDLE;
              end else if (wr_count == AW'(DEPTH - 1)) begin
                // Packet already fills the whole ring without a last word.
                state_next = DROP;
              end else begin
                state_next = WRITE;
              end
            end
          end
        end
        DROP: begin
          sink_ready = 1'b1;
          if (sink_valid && sink_last) begin
            rewind     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Read side: issue when committed data exists and the skid FIFO still has
  // room once the in-flight word and this cycle's handshake are accounted for.
  assign src_hs       = source_valid && source_ready;
  assign occ          = 3'(skid_cnt) + 3'(inflight);
  assign rd_issue     = !sys_rst && (avail != '0) && (occ < (3'd2 + 3'(src_hs)));
  assign cap_last     = (rd_addr_q == pkt_end[pf_rd]);
  assign source_valid = (skid_cnt != 2'd0);
  assign source_data  = skid_data[skid_rp];
  assign source_last  = skid_last[skid_rp];

  assign sram_ce_rw1   = wr_en;
  assign sram_we_rw1   = wr_en;
  assign sram_wmask    = '1;
  assign sram_addr_rw1 = wr_ptr;
  assign sram_wd_rw1   = sink_data;
  assign sram_ce_r1    = rd_issue;
  assign sram_addr_r1  = rd_ptr;

  always_ff @(posedge sys_clk) begin
    if (commit) pkt_end[pf_wr] <= wr_ptr;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      wr_count     <= '0;
      avail        <= '0;
      level        <= '0;
      pkt_count    <= '0;
      drop         <= 1'b0;
      pf_wr        <= '0;
      pf_rd        <= '0;
      inflight     <= 1'b0;
      rd_addr_q    <= '0;
      skid_data[0] <= '0;
      skid_data[1] <= '0;
      skid_last[0] <= 1'b0;
      skid_last[1] <= 1'b0;
      skid_wp      <= 1'b0;
      skid_rp      <= 1'b0;
      skid_cnt     <= '0;
    end else begin
      state <= state_next;

      if (wr_en)       wr_ptr <= ptr_inc(wr_ptr);
      else if (rewind) wr_ptr <= commit_ptr;

      if (commit || rewind) wr_count <= '0;
      else if (wr_en)       wr_count <= wr_count + 1'b1;

      if (commit) begin
        commit_ptr <= ptr_inc(wr_ptr);
        pf_wr      <= pf_wr + 1'b1;
      end

      avail     <= avail + (commit ? wr_count + AW'(1) : '0) - AW'(rd_issue);
      // A rewind can coincide with a source handshake; both are subtracted.
      level     <= level + AW'(wr_en) - AW'(src_hs) - (rewind ? wr_count : '0);
      pkt_count <= pkt_count + 4'(commit) - 4'(src_hs && source_last);
      drop      <= rewind;

      if (rd_issue) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        rd_addr_q <= rd_ptr;
      end
      inflight <= rd_issue;

      if (inflight) begin
        skid_data[skid_wp] <= sram_rd_r1;
        skid_last[skid_wp] <= cap_last;
        skid_wp            <= ~skid_wp;
        if (cap_last) pf_rd <= pf_rd + 1'b1;
      end
      if (src_hs) skid_rp <= ~skid_rp;
      skid_cnt <= skid_cnt + 2'(inflight) - 2'(src_hs);
    end
  end

endmodule

// File: tb/tb_liteeth_sram_pkt_ring_ctrl.sv
// tb_liteeth_sram_pkt_ring_ctrl
//   Directed bench for the packet ring controller with a behavioural model of
//   the 1RW/1R SRAM macro and a queue of expected source words.
module tb_liteeth_sram_pkt_ring_ctrl;
  localparam int unsigned DW = 32, DEPTH = 384, AW = 9, MAX_PKTS = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          sink_valid = 1'b0, sink_ready, sink_last = 1'b0;
  logic [DW-1:0] sink_data = '0;
  logic          source_valid, source_ready = 1'b0, source_last;
  logic [DW-1:0] source_data;
  logic          drop;
  logic [AW-1:0] level;
  logic [3:0]    pkt_count;
  logic          sram_ce_rw1, sram_we_rw1, sram_ce_r1;
  logic [DW-1:0] sram_wmask, sram_wd_rw1;
  logic [AW-1:0] sram_addr_rw1, sram_addr_r1;
  logic [DW-1:0] sram_rd_r1 = '0;

  always #5 sys_clk = ~sys_clk;

  liteeth_sram_pkt_ring_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .MAX_PKTS(MAX_PKTS)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data), .sink_last(sink_last),
    .source_valid(source_valid), .source_ready(source_ready), .source_data(source_data),
    .source_last(source_last), .drop(drop), .level(level), .pkt_count(pkt_count),
    .sram_ce_rw1(sram_ce_rw1), .sram_we_rw1(sram_we_rw1), .sram_wmask(sram_wmask),
    .sram_addr_rw1(sram_addr_rw1), .sram_wd_rw1(sram_wd_rw1),
    .sram_ce_r1(sram_ce_r1), .sram_addr_r1(sram_addr_r1), .sram_rd_r1(sram_rd_r1)
  );

  // SRAM macro model: registered read, data valid the cycle after ce_r1.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge sys_clk) begin
    if (sram_ce_rw1 && sram_we_rw1) mem[sram_addr_rw1] <= sram_wd_rw1;
    if (sram_ce_r1) sram_rd_r1 <= mem[sram_addr_r1];
  end

  int unsigned   n_checks = 0, n_pass = 0, drop_cnt = 0, d0;
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] wr_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (drop) drop_cnt++;
      if (sram_ce_rw1 && sram_we_rw1) wr_log.push_back(sram_addr_rw1);
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          check("src_extra", exp_q.size(), 1);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("src_data", source_data, e[DW-1:0]);
          check("src_last", 32'(source_last), 32'(e[DW]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic send_pkt(input int unsigned n, input logic [31:0] base, input bit keep);
    int unsigned t;
    for (int unsigned i = 0; i < n; i++) begin
      t = 0;
      sink_valid = 1'b1;
      sink_data  = base + i;
      sink_last  = (i == n - 1);
      @(negedge sys_clk);
      while (!sink_ready && t < 5000) begin
        t++;
        @(negedge sys_clk);
      end
      if (!sink_ready) begin
        check("send_timeout", 32'(sink_ready), 1);
        sink_valid = 1'b0;
        return;
      end
      @(posedge sys_clk); #1;
      if (keep) exp_q.push_back({sink_last, sink_data});
    end
    sink_valid = 1'b0;
    sink_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int unsigned t;
    t = 0;
    source_ready = 1'b1;
    while ((exp_q.size() != 0 || level != 0) && t < 5000) begin
      tick();
      t++;
    end
    check(tag, 32'(level), 0);
    check({tag, "_q"}, exp_q.size(), 0);
    check({tag, "_pkts"}, 32'(pkt_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_sink_ready", 32'(sink_ready), 0);
    check("rst_src_valid", 32'(source_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_pkts", 32'(pkt_count), 0);
    check("rst_ce_r1", 32'(sram_ce_r1), 0);
    check("rst_wmask", sram_wmask, 32'hffff_ffff);
    sys_rst = 1'b0;
    tick();
    check("idle_ready", 32'(sink_ready), 1);

    // 1: 4-word packet, addresses 0..3, 2-cycle first-word latency
    source_ready = 1'b0;
    wr_log.delete();
    send_pkt(4, 32'h1, 1);
    check("t1_lat0", 32'(source_valid), 0);
    tick();
    check("t1_lat1", 32'(source_valid), 0);
    tick();
    check("t1_lat2", 32'(source_valid), 1);
    check("t1_first", source_data, 32'h1);
    check("t1_level", 32'(level), 4);
    check("t1_pkts", 32'(pkt_count), 1);
    check("t1_nlog", wr_log.size(), 4);
    for (int unsigned i = 0; i < 4; i++) check("t1_addr", 32'(wr_log[i]), i);
    drain("t1_drain");

    // 2: wrap from address 380
    source_ready = 1'b1;
    send_pkt(376, 32'h1000, 1);
    drain("t2_pre");
    wr_log.delete();
    send_pkt(8, 32'h2000, 1);
    check("t2_nlog", wr_log.size(), 8);
    for (int unsigned i = 0; i < 8; i++) check("t2_addr", 32'(wr_log[i]), (380 + i) % 384);
    drain("t2_drain");

    // 3: fill the ring exactly with committed packets
    source_ready = 1'b0;
    d0 = drop_cnt;
    send_pkt(100, 32'h3000, 1);
    send_pkt(100, 32'h4000, 1);
    send_pkt(184, 32'h5000, 1);
    tick(); tick();
    check("t3_level", 32'(level), 384);
    check("t3_ready", 32'(sink_ready), 0);
    check("t3_pkts", 32'(pkt_count), 3);
    check("t3_drop", drop_cnt, d0);
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    check("t3_level_pop", 32'(level), 383);
    check("t3_ready_pop", 32'(sink_ready), 1);
    drain("t3_drain");

    // 4: overflowing packet is dropped and rewound
    source_ready = 1'b0;
    send_pkt(380, 32'h6000, 1);
    d0 = drop_cnt;
    send_pkt(10, 32'h7000, 0);
    tick(); tick();
    check("t4_drop", drop_cnt, d0 + 1);
    check("t4_level", 32'(level), 380);
    check("t4_pkts", 32'(pkt_count), 1);
    check("t4_ready", 32'(sink_ready), 1);
    drain("t4_drain");
    send_pkt(5, 32'h8000, 1);
    drain("t4_next");

    // 5: end-address FIFO full
    source_ready = 1'b0;
    for (int unsigned i = 0; i < 8; i++) send_pkt(1, 32'h9000 + i, 1);
    tick();
    check("t5_pkts", 32'(pkt_count), 8);
    check("t5_ready", 32'(sink_ready), 0);
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    check("t5_pkts_pop", 32'(pkt_count), 7);
    check("t5_ready_pop", 32'(sink_ready), 1);
    send_pkt(1, 32'h9008, 1);
    drain("t5_drain");

    // 6: reset mid-packet with a read in flight
    source_ready = 1'b1;
    send_pkt(6, 32'hA000, 1);
    sink_valid = 1'b1; sink_last = 1'b0; sink_data = 32'hB000;
    tick();
    sink_data = 32'hB001;
    tick();
    check("t6_inflight", 32'(sram_ce_r1), 1);
    sys_rst = 1'b1;
    sink_valid = 1'b0;
    sink_data = '0;
    exp_q.delete();
    tick();
    check("t6_sink_ready", 32'(sink_ready), 0);
    check("t6_src_valid", 32'(source_valid), 0);
    check("t6_src_data", source_data, 0);
    check("t6_src_last", 32'(source_last), 0);
    check("t6_drop", 32'(drop), 0);
    check("t6_level", 32'(level), 0);
    check("t6_pkts", 32'(pkt_count), 0);
    check("t6_ce_rw1", 32'(sram_ce_rw1), 0);
    check("t6_we_rw1", 32'(sram_we_rw1), 0);
    check("t6_ce_r1", 32'(sram_ce_r1), 0);
    check("t6_addr_rw1", 32'(sram_addr_rw1), 0);
    check("t6_addr_r1", 32'(sram_addr_r1), 0);
    sys_rst = 1'b0;
    tick(); tick(); tick();
    check("t6_no_stale", 32'(source_valid), 0);
    send_pkt(4, 32'hC000, 1);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
